// File: rtl/hazard_pkg.sv
// Shared types and bit positions for the pipeline hazard controller.
// Control-bus bit indices follow the ID/EX control encoding of the MIPS core.
package hazard_pkg;

    localparam int REG_W = 5;

    localparam int WB_REGWRITE  = 1;
    localparam int WB_MEMTOREG  = 0;

    localparam int MEM_BRANCH   = 2;
    localparam int MEM_MEMREAD  = 1;
    localparam int MEM_MEMWRITE = 0;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // One shadow pipeline stage; the all-zero value is a bubble.
    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic [1:0]       wb;
        logic             branch;
        logic             memread;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
    } stage_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_FLUSH,
        ST_FREEZE
    } haz_mode_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one EX source register; purely combinational.
// The EX/MEM result is newer than MEM/WB, so it wins; register $0 never forwards.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] mem_dest,
    input  logic          mem_regwrite,
    input  logic [AW-1:0] wb_dest,
    input  logic          wb_regwrite,
    output logic [1:0]    sel
);

    always_comb begin
        sel = FWD_REG;
        if (mem_regwrite && (mem_dest != '0) && (mem_dest == src)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_dest != '0) && (wb_dest == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: forwarding selects, load-use stall, branch flush, memory freeze.
// Optional HAZ_PERF_EN builds saturating stall/flush counters; otherwise those ports read 0.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_instr20_16,
    input  logic [REG_AW-1:0] id_instr15_11,
    input  logic              id_regdst,
    input  logic [1:0]        id_wb,
    input  logic [2:0]        id_mem,
    input  logic              zFlag,
    input  logic              mem_busy,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pc_src,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    stage_t    ex_q, mem_q, wb_q, id_s;
    haz_mode_t mode;
    logic      load_use, br_taken;
    logic [1:0] sel_a, sel_b;
    logic      unused_memwrite;

    assign unused_memwrite = id_mem[MEM_MEMWRITE];

    always_comb begin
        id_s         = '0;
        id_s.dest    = id_regdst ? id_instr15_11 : id_instr20_16;
        id_s.wb      = id_wb;
        id_s.branch  = id_mem[MEM_BRANCH];
        id_s.memread = id_mem[MEM_MEMREAD];
        id_s.rs      = id_rs;
        id_s.rt      = id_rt;
    end

    always_comb begin
        load_use = id_valid && ex_q.memread && (ex_q.dest != '0) &&
                   ((ex_q.dest == id_rs) || (id_uses_rt && (ex_q.dest == id_rt)));
        br_taken = ex_q.branch && zFlag;
        // The stalled instruction behind a taken branch is wrong-path, so flush outranks stall.
        if (!rst_n)        mode = ST_RUN;
        else if (mem_busy) mode = ST_FREEZE;
        else if (br_taken) mode = ST_FLUSH;
        else if (load_use) mode = ST_STALL;
        else               mode = ST_RUN;
    end

    assign pc_write    = (mode == ST_RUN) || (mode == ST_FLUSH);
    assign ifid_write  = (mode == ST_RUN) || (mode == ST_FLUSH);
    assign ifid_flush  = (mode == ST_FLUSH);
    assign pc_src      = (mode == ST_FLUSH);
    assign idex_bubble = (mode == ST_FLUSH) || (mode == ST_STALL);

    fwd_sel #(.AW(REG_W)) u_fwd_rs (
        .src          (ex_q.rs),
        .mem_dest     (mem_q.dest),
        .mem_regwrite (mem_q.wb[WB_REGWRITE]),
        .wb_dest      (wb_q.dest),
        .wb_regwrite  (wb_q.wb[WB_REGWRITE]),
        .sel          (sel_a)
    );

    fwd_sel #(.AW(REG_W)) u_fwd_rt (
        .src          (ex_q.rt),
        .mem_dest     (mem_q.dest),
        .mem_regwrite (mem_q.wb[WB_REGWRITE]),
        .wb_dest      (wb_q.dest),
        .wb_regwrite  (wb_q.wb[WB_REGWRITE]),
        .sel          (sel_b)
    );

    assign fwd_a = rst_n ? sel_a : FWD_REG;
    assign fwd_b = rst_n ? sel_b : FWD_REG;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_busy) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= (idex_bubble || !id_valid) ? '0 : id_s;
        end
    end

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Counters only move in STALL/FLUSH, so a freeze holds them implicitly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((mode == ST_STALL) && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if ((mode == ST_FLUSH) && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: per-cycle instruction stream with hand-derived expected controls.
// Expected records are queued when ID is driven and popped when outputs are sampled.
module tb_hazard_ctrl;

    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           id_valid;
    logic [4:0]     id_rs, id_rt, id_instr20_16, id_instr15_11;
    logic           id_uses_rt, id_regdst;
    logic [1:0]     id_wb;
    logic [2:0]     id_mem;
    logic           zFlag, mem_busy;
    logic [1:0]     fwd_a, fwd_b;
    logic           pc_write, ifid_write, ifid_flush, idex_bubble, pc_src;
    logic [CW-1:0]  stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_instr20_16(id_instr20_16), .id_instr15_11(id_instr15_11),
        .id_regdst(id_regdst), .id_wb(id_wb), .id_mem(id_mem), .zFlag(zFlag), .mem_busy(mem_busy),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pc_src(pc_src),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, pc_src}
    localparam logic [4:0] RUN   = 5'b11000;
    localparam logic [4:0] STALL = 5'b00010;
    localparam logic [4:0] FLUSH = 5'b11111;
    localparam logic [4:0] FRZ   = 5'b00000;

    typedef struct {
        logic       valid;
        logic [4:0] rs, rt, i20, i15;
        logic       uses_rt, regdst;
        logic [1:0] wb;
        logic [2:0] mem;
        logic       zf, busy;
        logic [1:0] fa, fb;
        logic [4:0] ctl;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t i_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        vec_t v = '{default: '0};
        v.valid = 1; v.rs = rs; v.rt = rt; v.uses_rt = 1; v.i20 = rt; v.i15 = rd;
        v.regdst = 1; v.wb = 2'b10; v.mem = 3'b000;
        return v;
    endfunction

    function automatic vec_t i_lw(input logic [4:0] rt, input logic [4:0] rs);
        vec_t v = '{default: '0};
        v.valid = 1; v.rs = rs; v.rt = rt; v.uses_rt = 0; v.i20 = rt; v.i15 = 5'd0;
        v.regdst = 0; v.wb = 2'b11; v.mem = 3'b010;
        return v;
    endfunction

    function automatic vec_t i_beq(input logic [4:0] rs, input logic [4:0] rt);
        vec_t v = '{default: '0};
        v.valid = 1; v.rs = rs; v.rt = rt; v.uses_rt = 1; v.i20 = rt;
        v.wb = 2'b00; v.mem = 3'b100;
        return v;
    endfunction

    function automatic vec_t i_nop();
        vec_t v = '{default: '0};
        return v;
    endfunction

    task automatic add(input vec_t b, input logic zf, input logic busy,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [4:0] ctl);
        vec_t v = b;
        v.zf = zf; v.busy = busy; v.fa = fa; v.fb = fb; v.ctl = ctl;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.valid; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt;
        id_instr20_16 = v.i20; id_instr15_11 = v.i15; id_regdst = v.regdst;
        id_wb = v.wb; id_mem = v.mem; zFlag = v.zf; mem_busy = v.busy;
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx);
        vec_t e = sb.pop_front();
        chk("fwd_a", idx, {14'd0, fwd_a}, {14'd0, e.fa});
        chk("fwd_b", idx, {14'd0, fwd_b}, {14'd0, e.fb});
        chk("ctl",   idx, {11'd0, pc_write, ifid_write, ifid_flush, idex_bubble, pc_src},
                          {11'd0, e.ctl});
    endtask

    task automatic step(input vec_t v, input int idx);
        drive(v);
        sb.push_back(v);
        @(negedge clk);
        check_outputs(idx);
        @(posedge clk);
        #1;
    endtask

    vec_t x;
    logic [CW-1:0] exp_stall, exp_flush;

    initial begin
        // Forwarding from EX/MEM, then from MEM/WB with one nop between
        add(i_r(3,1,2), 0,0, 2'b00,2'b00, RUN);
        add(i_r(4,3,5), 0,0, 2'b00,2'b00, RUN);
        add(i_nop(),    0,0, 2'b10,2'b00, RUN);
        add(i_nop(),    0,0, 2'b00,2'b00, RUN);
        add(i_r(3,1,2), 0,0, 2'b00,2'b00, RUN);
        add(i_nop(),    0,0, 2'b00,2'b00, RUN);
        add(i_r(4,3,5), 0,0, 2'b00,2'b00, RUN);
        add(i_nop(),    0,0, 2'b01,2'b00, RUN);
        add(i_nop(),    0,0, 2'b00,2'b00, RUN);
        add(i_nop(),    0,0, 2'b00,2'b00, RUN);
        // Load-use stall, add held in ID, then forwards from WB
        add(i_lw(2,1),  0,0, 2'b00,2'b00, RUN);
        add(i_r(4,2,3), 0,0, 2'b00,2'b00, STALL);
        add(i_r(4,2,3), 0,0, 2'b00,2'b00, RUN);
        add(i_nop(),    0,0, 2'b01,2'b00, RUN);
        // Taken and not-taken branch
        add(i_beq(1,1), 0,0, 2'b00,2'b00, RUN);
        add(i_r(7,1,1), 1,0, 2'b00,2'b00, FLUSH);
        add(i_nop(),    0,0, 2'b00,2'b00, RUN);
        add(i_beq(1,1), 0,0, 2'b00,2'b00, RUN);
        add(i_nop(),    0,0, 2'b00,2'b00, RUN);
        // Register $0 never forwards or stalls
        add(i_r(0,1,2), 0,0, 2'b00,2'b00, RUN);
        add(i_lw(0,1),  0,0, 2'b00,2'b00, RUN);
        add(i_r(4,0,0), 0,0, 2'b00,2'b00, RUN);
        add(i_nop(),    0,0, 2'b00,2'b00, RUN);
        // lw whose rt is not a source does not stall; rt forwards from MEM
        add(i_lw(6,1),  0,0, 2'b00,2'b00, RUN);
        add(i_lw(6,1),  0,0, 2'b00,2'b00, RUN);
        add(i_nop(),    0,0, 2'b00,2'b10, RUN);
        // Freeze during a load-use, stall resumes after release
        add(i_lw(2,1),  0,0, 2'b00,2'b00, RUN);
        add(i_r(4,2,3), 0,1, 2'b00,2'b00, FRZ);
        add(i_r(4,2,3), 0,1, 2'b00,2'b00, FRZ);
        add(i_r(4,2,3), 0,1, 2'b00,2'b00, FRZ);
        add(i_r(4,2,3), 0,0, 2'b00,2'b00, STALL);
        add(i_r(4,2,3), 0,0, 2'b00,2'b00, RUN);
        add(i_nop(),    0,0, 2'b01,2'b00, RUN);
        // Flush outranks a simultaneous load-use
        x = i_lw(9,1); x.mem = 3'b110; x.wb = 2'b00;
        add(x,          0,0, 2'b00,2'b00, RUN);
        add(i_r(5,9,1), 1,0, 2'b00,2'b00, FLUSH);
        add(i_nop(),    0,0, 2'b00,2'b00, RUN);
        // Freeze outranks a taken branch; flush follows release
        add(i_beq(1,1), 0,0, 2'b00,2'b00, RUN);
        add(i_nop(),    1,1, 2'b00,2'b00, FRZ);
        add(i_nop(),    1,0, 2'b00,2'b00, FLUSH);
        add(i_nop(),    0,0, 2'b00,2'b00, RUN);

        // Reset state
        rst_n = 0;
        drive(i_nop());
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(tbl[0]);
        sb[0].fa = 2'b00; sb[0].fb = 2'b00; sb[0].ctl = RUN;
        @(negedge clk);
        check_outputs(-1);
        chk("stall_cnt_rst", -1, stall_cnt, 16'd0);
        chk("flush_cnt_rst", -1, flush_cnt, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

`ifdef HAZ_PERF_EN
        exp_stall = 16'd2; exp_flush = 16'd3;
`else
        exp_stall = 16'd0; exp_flush = 16'd0;
`endif
        chk("stall_cnt", 100, stall_cnt, exp_stall);
        chk("flush_cnt", 100, flush_cnt, exp_flush);

        // Reset in the middle of a stall discards the load in EX
        x = i_lw(2,1);    x.fa = 0; x.fb = 0; x.ctl = RUN;   step(x, 200);
        x = i_r(4,2,3);   x.fa = 0; x.fb = 0; x.ctl = STALL; step(x, 201);
        drive(i_r(4,2,3));
        rst_n = 0;
        @(negedge clk);
        chk("pc_write_in_rst", 202, {15'd0, pc_write}, 16'd1);
        @(posedge clk);
        #1;
        rst_n = 1;
        chk("stall_cnt_clr", 203, stall_cnt, 16'd0);
        chk("flush_cnt_clr", 203, flush_cnt, 16'd0);
        x = i_r(4,2,3);   x.fa = 0; x.fb = 0; x.ctl = RUN;   step(x, 204);
        x = i_nop();      x.fa = 0; x.fb = 0; x.ctl = RUN;   step(x, 205);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; sits beside ID/EX/MEM/WB and steers the EX datapath.
- Keeps its own shadow pipeline of destination register, wb and mem control per stage.
- Produces EX operand forwarding selects, load-use stalls, branch-taken flush and a global freeze on memory busy.

Parameters:
- REG_AW, 5, register address width
- CNT_W, 16, width of performance counters (optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  ID source reg (instr25_21)
- id_rt  in  5  ID source reg (instr20_16)
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- id_instr20_16  in  5  rt dest candidate
- id_instr15_11  in  5  rd dest candidate
- id_regdst  in  1  1 = dest is instr15_11
- id_wb  in  2  {RegWrite, MemtoReg}
- id_mem  in  3  {Branch, MemRead, MemWrite}
- zFlag  in  1  EX ALU zero flag
- mem_busy  in  1  data memory not ready; freeze pipeline
- fwd_a  out  2  EX rs mux select
- fwd_b  out  2  EX rt mux select
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to nop
- idex_bubble  out  1  zero wb/mem controls into ID/EX
- pc_src  out  1  select brDst for next PC
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
- One clock clk; reset is synchronous and active-low (rst_n).
- Shadow stages EX, MEM and WB each hold dest[4:0], wb[1:0], branch, memread, rs, rt. Reset clears all to 0; a bubble is all-zero.
- Dest at ID = id_regdst ? id_instr15_11 : id_instr20_16.
- Advance each edge unless mem_busy:
  - WB <= MEM
  - MEM <= EX
  - EX <= ID fields, or bubble if idex_bubble or !id_valid
- Forwarding, combinational from shadow regs, for fwd_a on EX.rs (fwd_b identical on EX.rt):
  - 2'b10 if MEM.wb[1] && MEM.dest!=0 && MEM.dest==EX.rs
  - else 2'b01 if WB.wb[1] && WB.dest!=0 && WB.dest==EX.rs
  - else 2'b00
  - EX/MEM has priority over MEM/WB.
- load_use = id_valid && EX.memread && EX.dest!=0 && (EX.dest==id_rs || (id_uses_rt && EX.dest==id_rt)).
- br_taken = EX.branch && zFlag.
- Priority, highest first:
  - FREEZE (mem_busy): pc_write=0, ifid_write=0, bubble=0, flush=0, pc_src=0; shadow holds.
  - FLUSH (br_taken): pc_src=1, pc_write=1, ifid_flush=1, idex_bubble=1. Wins over a simultaneous load_use, since the stalled instruction is wrong-path.
  - STALL (load_use): pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle. The bubble enters EX, so load_use clears next cycle.
  - RUN: pc_write=1, ifid_write=1, all else 0.
- Register $0 never forwards and never stalls.
- Reset values: fwd_a/fwd_b=00, pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pc_src=0, counters 0. Reset mid-stall or mid-flush discards shadow contents at the next edge.
- Latency: forwarding and hazard outputs are valid in the same cycle as the shadow state; no added pipeline delay.

Optional Feature:
- Macro HAZ_PERF_EN.
- Defined: stall_cnt increments on each STALL cycle; flush_cnt increments on each FLUSH cycle. Both saturate at all-ones, hold during FREEZE, clear on reset.
- Undefined: ports remain but are tied to 0 and no counter logic is built.

Decomposition:
- Package hazard_pkg holds:
  - WB_REGWRITE=1, WB_MEMTOREG=0
  - MEM_BRANCH=2, MEM_MEMREAD=1, MEM_MEMWRITE=0
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - shadow-stage struct typedef
- Sub-module fwd_sel: combinational compare of one source reg against MEM/WB dest. Instantiated twice, for rs and rt.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 -> second in EX gives fwd_a=10, fwd_b=00. With one nop between -> fwd_a=01.
- lw $2,0($1) then add $4,$2,$3 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1, then fwd_a=01 in the add's EX cycle.
- beq in EX with zFlag=1 -> pc_src=1, ifid_flush=1, idex_bubble=1 same cycle. With zFlag=0 -> all 0.
- Writes to $0 followed by a reader of $0 -> fwd=00, no stall.
- mem_busy high 3 cycles during load-use -> pc_write=0, bubble=0, shadow unchanged; stall resumes after release.
- HAZ_PERF_EN: 2 stalls + 1 flush -> stall_cnt=2, flush_cnt=1. rst_n low one edge -> both 0.
